aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Parametrised AES key-schedule engine with a built-in round-key store, replacing the fixed round-key ROM used by the iterative AES cores. It accepts a 128-, 192- or 256-bit cipher key and expands it on-chip into the full FIPS-197 schedule, one 32-bit word per cycle. The round-key bytes are then served through the same byte-addressed read port the AES datapath already uses, so new keys need no resynthesis. Target traces: key-schedule leakage in addition to round leakage.

## Interface
- `KEY_BITS`, default 128: cipher key size; legal values are 128, 192 and 256. Derived values:
  - Nk = KEY_BITS/32
  - Nr = Nk+6
  - Nw = 4*(Nr+1) = 44, 52 or 60 words
- `clk` in, 1: the single clock; all state changes on the rising edge.
- `reset` in, 1: asynchronous, active-high.
- `key_load` in, 1: single-cycle start pulse; `key_in` is sampled on the same edge.
- `key_in` in, KEY_BITS: cipher key. Key byte 0 is `key_in[KEY_BITS-1 -: 8]`.
- `busy` out, 1: high while expansion is in progress.
- `ready` out, 1: high when the full schedule is valid.
- `rd_addr` in, 8: round-key byte address, 0..4*Nw-1.
- `rd_data` out, 8: registered round-key byte.

## Operation
- FSM states are IDLE and EXPAND.
- Edge E0 with `key_load`=1, in any state:
  - Write key words w[0..Nk-1]. Word k is `key_in` bytes 4k..4k+3, byte 4k at the MSB.
  - Set i=Nk, j=0 (i mod Nk), rcon=8'h01.
  - Go to EXPAND; `busy`=1, `ready`=0.
- EXPAND, each edge, write w[i] = w[i-Nk] ^ t, where t is:
  - j==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}. After use, rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
  - Nk==8 and j==4: SubWord(w[i-1]).
  - otherwise: w[i-1].
  - Then i++, and j wraps at Nk.
- Final write (i==Nw-1): go to IDLE on the same edge; `busy`=0, `ready`=1.
- `key_load` during EXPAND aborts the run and restarts from E0 with the new key; `ready` stays 0.
- Read mapping: byte a = w[a>>2] byte (a&3), byte 0 at the MSB.
  - a >= 4*Nw returns 8'h00.
  - Reads during EXPAND return current storage contents (partial or stale). Consumers must gate on `ready`.
- Rounds are addressed 16 bytes apart, at base 16*r. This matches the existing AES core address map.

## Timing
- Reset, asynchronous, is the only clear of storage and outputs:
  - state IDLE, `busy`=0, `ready`=0, `rd_data`=8'h00.
  - All stored words 0, rcon=8'h01.
  - Reset mid-expansion discards the run; no write occurs on the reset edge.
- Latency from the E0 edge to `ready`=1 is Nw-Nk edges: 40 (128-bit), 46 (192-bit), 52 (256-bit).
  - `busy` rises at E0 and falls on the same edge that `ready` rises.
- Read latency is 1 cycle: `rd_data` reflects `rd_addr` sampled on the previous edge. Reads do not stall expansion.
- A read of w[i] issued on the same edge that w[i] is written returns the old value.
- `key_load` held high for several cycles restarts every cycle; the expansion completes Nw-Nk edges after the last high edge.

## Structure
- `aes_pkg` holds:
  - the S-box table
  - the `xtime` function
  - functions `aes_nk(KEY_BITS)`, `aes_nr(KEY_BITS)`, `aes_nw(KEY_BITS)`
  - the `RCON_INIT` constant
  - the `word_t` (logic [31:0]) typedef
- Sub-module `aes_sbox`: 8-bit combinational S-box lookup from `aes_pkg`, instanced 4× for SubWord. The same cell is shared with the datapath, so leakage models match.
- Word storage is a flop array of Nw x `word_t` with asynchronous reset.
- Width rules: i is 6 bits, j is 3 bits.

## Test plan
- 128-bit key 000102…0F, `key_load`, wait for `ready`:
  - `ready` rises after exactly 40 edges.
  - bytes 16..19 = D6 AA 74 FD
  - bytes 160..175 = 13 11 1D 7F E3 94 4A 17 F3 07 A7 8B 4D 2B 30 C5
- 128-bit FIPS-197 A.1 key 2B7E151628AED2A6ABF7158809CF4F3C: bytes 16..19 = A0 FA FE 17; bytes 172..175 = B6 63 0C A6.
- 256-bit FIPS-197 A.3 key 603DEB10…0914DFF4:
  - `ready` after 52 edges.
  - w[8]=9BA35411; w[12]=A8B09C1A (checks the j==4 SubWord path); w[59]=706C631E.
- Restart: load key 000102…0F, then at edge 10 load the A.1 key:
  - `busy` never drops and `ready` stays 0.
  - `ready` rises 40 edges after the second load; contents match the A.1 schedule.
- Reset mid-run: assert `reset` at edge 20 between clock edges:
  - `busy`, `ready` and `rd_data` go 0 immediately.
  - After release, every address reads 00.
- With KEY_BITS=128, `rd_addr`=200 reads 00 the next cycle; `rd_addr`=0 reads key byte 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, GF(2^8) doubling and
// key-size derived word counts.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int aes_nk(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int aes_nr(input int key_bits);
        return aes_nk(key_bits) + 6;
    endfunction

    function automatic int aes_nw(input int key_bits);
        return 4 * (aes_nr(key_bits) + 1);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational AES S-box; the same cell the round datapath uses.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// On-chip AES key schedule (128/192/256-bit keys), one word per cycle,
// with a registered byte-addressed round-key read port.
//   state  | meaning
//   IDLE   | schedule complete (ready) or never loaded
//   EXPAND | writing w[Nk..Nw-1], one word per edge
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_load,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                ready,
    input  logic [7:0]          rd_addr,
    output logic [7:0]          rd_data
);

    localparam int         NK       = aes_nk(KEY_BITS);
    localparam int         NW       = aes_nw(KEY_BITS);
    localparam logic [5:0] NK_I     = 6'(NK);
    localparam logic [5:0] NW_LAST  = 6'(NW - 1);
    localparam logic [2:0] J_LAST   = 3'(NK - 1);
    localparam logic [8:0] RD_LIMIT = 9'(4 * NW);

    typedef enum logic {IDLE, EXPAND} state_e;

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  j_q, j_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        ready_q, ready_d;
    logic [7:0]  rd_data_q, rd_data_d;
    word_t       words_q [NW];
    word_t       words_d [NW];

    logic        wr_en;
    logic        last_word;
    logic [5:0]  idx_prev, idx_base;
    word_t       prev_w, base_w, sub_in, sub_out, temp_w, new_w, rd_word;

    assign last_word = (i_q == NW_LAST);
    assign idx_prev  = i_q - 6'd1;
    assign idx_base  = i_q - NK_I;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (key_load) begin
            state_d = EXPAND;
        end else if (state_q == EXPAND && last_word) begin
            state_d = IDLE;
        end
    end

    // A load on the same edge wins over the pending expansion write.
    always_comb begin
        busy  = (state_q == EXPAND);
        wr_en = (state_q == EXPAND) && !key_load;
    end

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        ready_d = ready_q;
        if (key_load) begin
            i_d     = NK_I;
            j_d     = 3'd0;
            rcon_d  = RCON_INIT;
            ready_d = 1'b0;
        end else if (wr_en) begin
            i_d = i_q + 6'd1;
            j_d = (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
            if (j_q == 3'd0) begin
                rcon_d = xtime(rcon_q);
            end
            if (last_word) begin
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_q     <= 6'd0;
            j_q     <= 3'd0;
            rcon_q  <= RCON_INIT;
            ready_q <= 1'b0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        prev_w = '0;
        base_w = '0;
        if (state_q == EXPAND) begin
            prev_w = words_q[idx_prev];
            base_w = words_q[idx_base];
        end
    end

    assign sub_in = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp_w = prev_w;
        if (j_q == 3'd0) begin
            temp_w = sub_out ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && j_q == 3'd4) begin
            temp_w = sub_out;
        end
    end

    assign new_w = base_w ^ temp_w;

    always_comb begin
        words_d = words_q;
        if (key_load) begin
            for (int k = 0; k < NK; k++) begin
                words_d[k] = key_in[KEY_BITS-1-32*k -: 32];
            end
        end else if (wr_en) begin
            words_d[i_q] = new_w;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NW; k++) begin
                words_q[k] <= '0;
            end
        end else begin
            words_q <= words_d;
        end
    end

    // Reads see storage before this edge's write, so a same-edge read of w[i] is old data.
    always_comb begin
        rd_word   = '0;
        rd_data_d = 8'h00;
        if ({1'b0, rd_addr} < RD_LIMIT) begin
            rd_word = words_q[rd_addr[7:2]];
            case (rd_addr[1:0])
                2'd0:    rd_data_d = rd_word[31:24];
                2'd1:    rd_data_d = rd_word[23:16];
                2'd2:    rd_data_d = rd_word[15:8];
                default: rd_data_d = rd_word[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign ready   = ready_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: 128- and 256-bit instances checked
// against a FIPS-197 style key-schedule model built from GF(2^8) arithmetic.
module tb_aes_key_expand;

    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_A3  =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         reset;
    logic         kl_a, busy_a, ready_a;
    logic [127:0] ki_a;
    logic [7:0]   ra_a, rd_a;
    logic         kl_b, busy_b, ready_b;
    logic [255:0] ki_b;
    logic [7:0]   ra_b, rd_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] exp_w [60];
    int          exp_nw;

    always #5 clk = ~clk;

    aes_key_expand #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .reset(reset), .key_load(kl_a), .key_in(ki_a),
        .busy(busy_a), .ready(ready_a), .rd_addr(ra_a), .rd_data(rd_a)
    );

    aes_key_expand #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .reset(reset), .key_load(kl_b), .key_in(ki_b),
        .busy(busy_b), .ready(ready_b), .rd_addr(ra_b), .rd_data(rd_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // key is left-aligned: key byte 0 in key[255:248]
    task automatic model_expand(input int nk, input logic [255:0] key);
        logic [7:0]  rc;
        logic [31:0] t;
        exp_nw = 4 * (nk + 7);
        for (int k = 0; k < nk; k++) exp_w[k] = key[255-32*k -: 32];
        rc = 8'h01;
        for (int i = nk; i < exp_nw; i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gf_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        logic [31:0] w = exp_w[a/4];
        return w[31-8*(a%4) -: 8];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_load(input bit wide, input logic [255:0] key, input logic val);
        if (wide) begin
            kl_b = val;
            ki_b = key;
        end else begin
            kl_a = val;
            ki_a = key[255:128];
        end
    endtask

    task automatic pulse_load(input bit wide, input logic [255:0] key);
        drive_load(wide, key, 1'b1);
        @(posedge clk); #1;
        drive_load(wide, key, 1'b0);
    endtask

    task automatic read_byte(input bit wide, input int addr, output logic [7:0] d);
        if (wide) ra_b = 8'(addr);
        else      ra_a = 8'(addr);
        @(posedge clk); #1;
        d = wide ? rd_b : rd_a;
    endtask

    function automatic logic get_busy(input bit wide);
        return wide ? busy_b : busy_a;
    endfunction

    function automatic logic get_ready(input bit wide);
        return wide ? ready_b : ready_a;
    endfunction

    task automatic wait_ready(input bit wide, output int edges, output bit busy_bad);
        edges    = 0;
        busy_bad = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            edges++;
            if (get_ready(wide)) break;
            if (!get_busy(wide)) busy_bad = 1'b1;
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int n = 0; n < 8; n++) k[32*n +: 32] = $urandom();
        return k;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy128: got %b expected 0", busy_a); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready128: got %b expected 0", ready_a); end
        checks++; if (rd_a !== 8'h00)   begin errors++; $display("FAIL reset_rd128: got %h expected 00", rd_a); end
        checks++; if (busy_b !== 1'b0)  begin errors++; $display("FAIL reset_busy256: got %b expected 0", busy_b); end
        checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready256: got %b expected 0", ready_b); end
        @(posedge clk); #1;
        reset = 1'b0;
        read_byte(1'b0, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_store128: got %h expected 00", d); end
        read_byte(1'b1, 100, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_store256: got %h expected 00", d); end
    endtask

    task automatic test_kat_128();
        logic [7:0] d;
        int         edges;
        bit         bad;
        logic [7:0] r1 [4]  = '{8'hd6, 8'haa, 8'h74, 8'hfd};
        logic [7:0] r10 [16] = '{8'h13, 8'h11, 8'h1d, 8'h7f, 8'he3, 8'h94, 8'h4a, 8'h17,
                                 8'hf3, 8'h07, 8'ha7, 8'h8b, 8'h4d, 8'h2b, 8'h30, 8'hc5};
        model_expand(4, {KEY_SEQ, 128'h0});
        pulse_load(1'b0, {KEY_SEQ, 128'h0});
        checks++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
            errors++; $display("FAIL kat128_start: busy %b ready %b expected busy 1 ready 0", busy_a, ready_a);
        end
        wait_ready(1'b0, edges, bad);
        checks++; if (edges != 40) begin errors++; $display("FAIL kat128_latency: got %0d expected 40", edges); end
        checks++; if (bad) begin errors++; $display("FAIL kat128_busy_gap: busy dropped before ready"); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL kat128_busy_end: got %b expected 0", busy_a); end
        for (int a = 0; a < 4; a++) begin
            read_byte(1'b0, 16 + a, d);
            checks++; if (d !== r1[a]) begin errors++; $display("FAIL kat128_round1 addr %0d: got %h expected %h", 16 + a, d, r1[a]); end
        end
        for (int a = 0; a < 16; a++) begin
            read_byte(1'b0, 160 + a, d);
            checks++; if (d !== r10[a]) begin errors++; $display("FAIL kat128_round10 addr %0d: got %h expected %h", 160 + a, d, r10[a]); end
        end
        for (int a = 0; a < exp_nw * 4; a++) begin
            read_byte(1'b0, a, d);
            checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL kat128_sched addr %0d: got %h expected %h", a, d, exp_byte(a)); end
        end
    endtask

    task automatic test_fips_a1();
        logic [7:0] d;
        int         edges;
        bit         bad;
        logic [7:0] r1 [4]  = '{8'ha0, 8'hfa, 8'hfe, 8'h17};
        logic [7:0] rl [4]  = '{8'hb6, 8'h63, 8'h0c, 8'ha6};
        model_expand(4, {KEY_A1, 128'h0});
        pulse_load(1'b0, {KEY_A1, 128'h0});
        wait_ready(1'b0, edges, bad);
        checks++; if (edges != 40 || bad) begin errors++; $display("FAIL a1_latency: got %0d gap %b expected 40 gap 0", edges, bad); end
        for (int a = 0; a < 4; a++) begin
            read_byte(1'b0, 16 + a, d);
            checks++; if (d !== r1[a]) begin errors++; $display("FAIL a1_round1 addr %0d: got %h expected %h", 16 + a, d, r1[a]); end
            read_byte(1'b0, 172 + a, d);
            checks++; if (d !== rl[a]) begin errors++; $display("FAIL a1_w43 addr %0d: got %h expected %h", 172 + a, d, rl[a]); end
        end
        for (int a = 0; a < exp_nw * 4; a++) begin
            read_byte(1'b0, a, d);
            checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL a1_sched addr %0d: got %h expected %h", a, d, exp_byte(a)); end
        end
    endtask

    // DUT holds the A.1 schedule on entry.
    task automatic test_read_during_expand();
        logic [7:0]   old_b, new_b;
        logic [255:0] key;
        int           edges;
        bit           bad;
        model_expand(4, {KEY_A1, 128'h0});
        old_b = exp_byte(16);
        key = rand_key();
        model_expand(4, key);
        new_b = exp_byte(16);
        ra_a = 8'd16;
        pulse_load(1'b0, key);
        checks++; if (rd_a !== old_b) begin errors++; $display("FAIL rde_e0: got %h expected %h", rd_a, old_b); end
        @(posedge clk); #1;
        checks++; if (rd_a !== old_b) begin errors++; $display("FAIL rde_same_edge: got %h expected %h", rd_a, old_b); end
        @(posedge clk); #1;
        checks++; if (rd_a !== new_b) begin errors++; $display("FAIL rde_after: got %h expected %h", rd_a, new_b); end
        wait_ready(1'b0, edges, bad);
        checks++; if (edges != 38) begin errors++; $display("FAIL rde_latency: got %0d expected 38", edges); end
    endtask

    task automatic test_fips_a3();
        logic [7:0]  d;
        logic [31:0] w;
        int          edges;
        bit          bad;
        int          widx [3] = '{8, 12, 59};
        logic [31:0] wexp [3] = '{32'h9ba35411, 32'ha8b09c1a, 32'h706c631e};
        model_expand(8, KEY_A3);
        pulse_load(1'b1, KEY_A3);
        wait_ready(1'b1, edges, bad);
        checks++; if (edges != 52) begin errors++; $display("FAIL a3_latency: got %0d expected 52", edges); end
        checks++; if (bad) begin errors++; $display("FAIL a3_busy_gap: busy dropped before ready"); end
        for (int n = 0; n < 3; n++) begin
            for (int b = 0; b < 4; b++) begin
                read_byte(1'b1, 4 * widx[n] + b, d);
                w[31-8*b -: 8] = d;
            end
            checks++; if (w !== wexp[n]) begin errors++; $display("FAIL a3_word w[%0d]: got %h expected %h", widx[n], w, wexp[n]); end
        end
        for (int a = 0; a < exp_nw * 4; a++) begin
            read_byte(1'b1, a, d);
            checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL a3_sched addr %0d: got %h expected %h", a, d, exp_byte(a)); end
        end
    endtask

    task automatic test_random();
        logic [7:0]   d;
        logic [255:0] key;
        int           edges, lat;
        bit           bad, wide;
        for (int n = 0; n < 6; n++) begin
            wide = n[0];
            key  = rand_key();
            if (!wide) key[127:0] = '0;
            model_expand(wide ? 8 : 4, key);
            lat = exp_nw - (wide ? 8 : 4);
            pulse_load(wide, key);
            wait_ready(wide, edges, bad);
            checks++; if (edges != lat || bad) begin
                errors++; $display("FAIL rand%0d_latency: got %0d gap %b expected %0d gap 0", n, edges, bad, lat);
            end
            for (int a = 0; a < exp_nw * 4; a++) begin
                read_byte(wide, a, d);
                checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL rand%0d_sched addr %0d: got %h expected %h", n, a, d, exp_byte(a)); end
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] d;
        int         edges;
        bit         bad, bad2;
        pulse_load(1'b0, {KEY_SEQ, 128'h0});
        bad = 1'b0;
        for (int n = 0; n < 9; n++) begin
            @(posedge clk); #1;
            if (!busy_a || ready_a) bad = 1'b1;
        end
        pulse_load(1'b0, {KEY_A1, 128'h0});
        checks++; if (bad || busy_a !== 1'b1 || ready_a !== 1'b0) begin
            errors++; $display("FAIL restart_flags: gap %b busy %b ready %b expected gap 0 busy 1 ready 0", bad, busy_a, ready_a);
        end
        wait_ready(1'b0, edges, bad2);
        checks++; if (edges != 40 || bad2) begin errors++; $display("FAIL restart_latency: got %0d gap %b expected 40 gap 0", edges, bad2); end
        model_expand(4, {KEY_A1, 128'h0});
        for (int a = 0; a < exp_nw * 4; a++) begin
            read_byte(1'b0, a, d);
            checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL restart_sched addr %0d: got %h expected %h", a, d, exp_byte(a)); end
        end
    endtask

    task automatic test_held_load();
        logic [7:0]   d;
        logic [255:0] k1, k2, k3;
        int           edges;
        bit           bad;
        k1 = {rand_key()[255:128], 128'h0};
        k2 = {rand_key()[255:128], 128'h0};
        k3 = {rand_key()[255:128], 128'h0};
        drive_load(1'b0, k1, 1'b1);
        @(posedge clk); #1;
        drive_load(1'b0, k2, 1'b1);
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
            errors++; $display("FAIL held_flags: busy %b ready %b expected busy 1 ready 0", busy_a, ready_a);
        end
        drive_load(1'b0, k3, 1'b1);
        @(posedge clk); #1;
        drive_load(1'b0, k3, 1'b0);
        wait_ready(1'b0, edges, bad);
        checks++; if (edges != 40 || bad) begin errors++; $display("FAIL held_latency: got %0d gap %b expected 40 gap 0", edges, bad); end
        model_expand(4, k3);
        for (int a = 0; a < exp_nw * 4; a++) begin
            read_byte(1'b0, a, d);
            checks++; if (d !== exp_byte(a)) begin errors++; $display("FAIL held_sched addr %0d: got %h expected %h", a, d, exp_byte(a)); end
        end
    endtask

    // exp_w still holds the held-load schedule.
    task automatic test_out_of_range();
        logic [7:0] d;
        int         addrs [5] = '{200, 176, 255, 175, 0};
        logic [7:0] expv [5];
        expv = '{8'h00, 8'h00, 8'h00, exp_byte(175), exp_byte(0)};
        for (int n = 0; n < 5; n++) begin
            read_byte(1'b0, addrs[n], d);
            checks++; if (d !== expv[n]) begin errors++; $display("FAIL oor addr %0d: got %h expected %h", addrs[n], d, expv[n]); end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0]   d;
        logic [255:0] key;
        key = {rand_key()[255:128], 128'h0};
        key[255:248] = 8'ha5;
        ra_a = 8'd0;
        pulse_load(1'b0, key);
        repeat (19) begin @(posedge clk); #1; end
        checks++; if (rd_a !== 8'ha5 || busy_a !== 1'b1) begin
            errors++; $display("FAIL midrst_before: rd %h busy %b expected rd a5 busy 1", rd_a, busy_a);
        end
        #3 reset = 1'b1;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready_a); end
        checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL midrst_rd: got %h expected 00", rd_a); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int a = 0; a < 176; a++) begin
            read_byte(1'b0, a, d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_store addr %0d: got %h expected 00", a, d); end
        end
        checks++; if (busy_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++; $display("FAIL midrst_after: busy %b ready %b expected 0 0", busy_a, ready_a);
        end
        read_byte(1'b1, 0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL midrst_store256: got %h expected 00", d); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        kl_a = 1'b0; ki_a = '0; ra_a = 8'h00;
        kl_b = 1'b0; ki_b = '0; ra_b = 8'h00;
        build_sbox();
        @(posedge clk); #1;
        test_reset();
        test_kat_128();
        test_fips_a1();
        test_read_during_expand();
        test_fips_a3();
        test_random();
        test_restart();
        test_held_load();
        test_out_of_range();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
